ds_cic_decim: RTL and testbench
===============================

// Module: ds_cic_decim
// PURPOSE
//  Sinc^N (CIC) decimator: the receive end of the delta-sigma modulator's 1-bit stream.
//  Maps each bit to +1/-1, integrates at the bit rate and decimates by OSR.
//  Differentiates at the output rate and presents signed multi-bit PCM words.
//  Output uses a valid/ready handshake.
//  Sits after the modulator (loopback/test) or after the external bitstream input.
// PARAMETERS
//  ORDER   3    number of integrator and comb stages (N), 1..5
//  OSR     64   decimation ratio R, power of two, 4..1024
//  OW      ORDER*$clog2(OSR)+2   accumulator and output width; must not be overridden smaller
// PORTS
//  clk        in   1    single clock
//  rst_n      in   1    asynchronous active-low reset
//  clr        in   1    synchronous clear of all state, same targets as reset
//  bs_valid   in   1    bs_in is a new modulator bit this cycle
//  bs_in      in   1    modulator bit: 1 -> +1, 0 -> -1
//  dout       out  OW   signed decimated sample, two's complement
//  dout_valid out  1    dout holds an unconsumed sample
//  dout_ready in   1    consumer accepts dout when dout_valid & dout_ready
//  ovr        out  1    sticky: a sample was dropped because the output was still occupied
// BEHAVIOUR
//  Reset (rst_n=0, async) or clr=1 (sync, highest priority):
//   - integrators, comb delays, phase counter and pipeline valids -> 0
//   - dout=0, dout_valid=0, ovr=0
//  Integrators: on bs_valid, I1 += (bs_in ? +1 : -1); Ik += I(k-1) for k=2..N.
//   Updates use pre-update values (registered cascade).
//   Arithmetic is OW-bit modular; wrap-around is intended, never saturate.
//  Phase counter: 0..OSR-1, advances only on bs_valid.
//   On bs_valid with count==OSR-1: count -> 0 and raise a decimation tick.
//   The tick samples IN the cycle after that integrator update.
//  Combs: N registered stages, one per clock, fed by the tick.
//   Stage k: y = x - z_k; z_k <= x. z_k updates only when the stage's valid is high.
//   Stages are OW-bit modular.
//  Latency: the clock edge accepting the OSR-th bit -> dout_valid high exactly N+2 edges later
//   (1 integrator, 1 sample, N comb).
//  Output register: the comb result loads dout and sets dout_valid.
//   dout_valid stays high and dout stable until the handshake.
//   Handshake completing with no new result -> dout_valid=0.
//   Handshake and new result in the same cycle -> load; dout_valid stays 1; no ovr.
//   New result, dout_valid=1, dout_ready=0 -> new result dropped, dout unchanged, ovr=1.
//  ovr clears only on reset/clr.
//  bs_valid=0 cycles stall the integrators and counter; combs and output keep running.
//  Gain: steady all-ones input gives +OSR^ORDER; all-zeros gives -OSR^ORDER.
//   OW is sized so that +/-OSR^ORDER is representable.
//  The first ORDER-1 outputs after reset/clr are transient. The ORDER-th and later outputs are settled.
// STRUCTURE
//  Shared package ds_pkg:
//   - function cic_width(order, osr)
//   - localparams BIT_POS=+1, BIT_NEG=-1
//   - default ORDER/OSR constants, also used by the modulator's testbench model
//  Sub-module ds_cic_comb: one comb stage (x, in_valid -> y, out_valid, internal delay reg).
//   Instantiated ORDER times in a generate loop.
//  Integrators, phase counter and output/handshake logic are inline.
// TESTING
//  - Reset/clr: assert rst_n=0 mid-stream -> all outputs 0 at once.
//    Repeat with clr=1 -> same on the next edge. Later outputs equal those of a freshly reset run.
//  - DC extremes (defaults): 192+ ones with bs_valid=1 -> 3rd and later dout = 262144.
//    All-zeros -> -262144. dout_valid rises exactly 5 clocks after the 64th bit.
//  - Idle pattern: alternating 1,0,... -> settled dout = 0.
//    Pattern 1,1,1,0 repeated -> settled dout = +131072.
//  - Gapped input: bs_valid random 30% duty -> dout sequence identical to the gap-free run;
//    counter and integrators do not advance on gaps.
//  - Backpressure: hold dout_ready=0 across two ticks -> first sample held, second dropped, ovr=1.
//    Then dout_ready=1 -> one handshake, dout_valid=0; ovr stays 1 until clr.
//  - Wrap: ORDER=5, OSR=1024 long DC+random run -> results match the bit-true model
//    despite integrator wrap; simultaneous handshake and load -> no ovr.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared delta-sigma package.
// Holds the default modulator/decimator sizing, the +1/-1 values that a
// modulator bit stands for, and the CIC accumulator width rule.
package ds_pkg;

  localparam int DEF_ORDER = 3;
  localparam int DEF_OSR   = 64;

  localparam int BIT_POS = 1;
  localparam int BIT_NEG = -1;

  // Width that holds +/-OSR^ORDER as a signed value.
  function automatic int cic_width(input int order, input int osr);
    return order * $clog2(osr) + 2;
  endfunction

endpackage

// File: rtl/ds_cic_comb.sv
// One CIC comb (differentiator) stage.
// Ports:
//   clk, rst_n (async active-low), clr (sync clear)
//   x / in_valid   : input sample and its strobe
//   y / out_valid  : registered difference x - z and its strobe
// The delay register z only advances on in_valid, so the stage differences
// consecutive decimated samples rather than consecutive clocks.
module ds_cic_comb
  import ds_pkg::*;
#(
  parameter int OW = cic_width(DEF_ORDER, DEF_OSR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [OW-1:0] x,
  input  logic          in_valid,
  output logic [OW-1:0] y,
  output logic          out_valid
);

  logic [OW-1:0] z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      z         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= x - z;
        z <= x;
      end
    end
  end

endmodule

// File: rtl/ds_cic_decim.sv
// Sinc^N (CIC) decimator for the delta-sigma 1-bit stream.
// Ports:
//   clk, rst_n (async active-low), clr (sync clear, highest priority)
//   bs_valid / bs_in : modulator bit strobe and value (1 -> +1, 0 -> -1)
//   dout             : signed decimated PCM word (OW bits)
//   dout_valid / dout_ready : output handshake
//   ovr              : sticky, a result was dropped while dout was occupied
// Pipeline: integrators (bit rate) -> sample register (tick) -> ORDER combs
// -> output register.  All arithmetic is OW-bit modular.
module ds_cic_decim
  import ds_pkg::*;
#(
  parameter int ORDER = DEF_ORDER,
  parameter int OSR   = DEF_OSR,
  parameter int OW    = cic_width(ORDER, OSR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 bs_valid,
  input  logic                 bs_in,
  output logic signed [OW-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 ovr
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] PH_LAST  = CW'(OSR - 1);
  localparam logic [OW-1:0] STEP_POS = OW'(BIT_POS);
  localparam logic [OW-1:0] STEP_NEG = OW'(BIT_NEG);

  logic [OW-1:0]          integ [ORDER];
  logic [CW-1:0]          phase;
  logic                   tick;
  logic [OW-1:0]          samp;
  logic                   samp_valid;
  logic [ORDER:0][OW-1:0] cx;
  logic [ORDER:0]         cv;

  // Integrator cascade: every stage reads the pre-update value of the one
  // before it, so stage k lags the ideal running sum by k-1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (clr) begin
      for (int unsigned k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (bs_valid) begin
      integ[0] <= integ[0] + (bs_in ? STEP_POS : STEP_NEG);
      for (int unsigned k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Phase counter and decimation tick; tick is registered so the sample
  // register sees the integrators after the OSR-th bit has been added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      tick       <= 1'b0;
      samp       <= '0;
      samp_valid <= 1'b0;
    end else if (clr) begin
      phase      <= '0;
      tick       <= 1'b0;
      samp       <= '0;
      samp_valid <= 1'b0;
    end else begin
      tick       <= bs_valid && (phase == PH_LAST);
      samp_valid <= tick;
      if (tick) samp <= integ[ORDER-1];
      if (bs_valid) phase <= (phase == PH_LAST) ? '0 : phase + CW'(1);
    end
  end

  assign cx[0] = samp;
  assign cv[0] = samp_valid;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    ds_cic_comb #(.OW(OW)) u_comb (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .x         (cx[k]),
      .in_valid  (cv[k]),
      .y         (cx[k+1]),
      .out_valid (cv[k+1])
    );
  end

  // Output register: a consumed slot may be refilled in the same cycle;
  // a result arriving at an occupied, unconsumed slot is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovr        <= 1'b0;
    end else if (clr) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovr        <= 1'b0;
    end else if (cv[ORDER]) begin
      if (!dout_valid || dout_ready) begin
        dout       <= $signed(cx[ORDER]);
        dout_valid <= 1'b1;
      end else begin
        ovr <= 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ds_cic_decim.sv
// Self-checking bench for ds_cic_decim.
// Reference: each output is the input (+1/-1, zero before start) convolved
// with the sinc^N kernel (boxcar of length OSR convolved N times), read at
// bit index m*OSR-N (the registered cascade adds N-1 bits of delay).
module tb_ds_cic_decim;
  import ds_pkg::*;

  localparam int A_OW = cic_width(3, 64);
  localparam int B_OW = cic_width(5, 1024);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, clr, bs_valid, bs_in, dout_ready;
  logic signed [A_OW-1:0] dout;
  logic                   dout_valid, ovr;

  logic                   b_rst_n, b_clr, b_bs_valid, b_bs_in, b_dout_ready;
  logic signed [B_OW-1:0] b_dout;
  logic                   b_dout_valid, b_ovr;

  ds_cic_decim dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bs_valid(bs_valid), .bs_in(bs_in),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .ovr(ovr)
  );

  ds_cic_decim #(.ORDER(5), .OSR(1024)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .clr(b_clr), .bs_valid(b_bs_valid), .bs_in(b_bs_in),
    .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .ovr(b_ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit     stim[$];
  bit     stim_b[$];
  longint rec[$];
  longint rec_b[$];
  longint expq[$];
  longint save[$];

  typedef struct {
    string  name;
    bit [3:0] pat;
    int     plen;
    longint settled;
  } vec_t;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic void cic_model(input bit bits[$], input int order, input int osr,
                                    input int ow, output longint res[$]);
    longint h[$];
    longint t[$];
    longint acc;
    int     idx;
    res.delete();
    h.push_back(1);
    for (int s = 0; s < order; s++) begin
      t.delete();
      for (int i = 0; i < h.size() + osr - 1; i++) t.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < osr; j++) t[i+j] += h[i];
      h = t;
    end
    for (int m = 1; m <= bits.size() / osr; m++) begin
      acc = 0;
      for (int j = 0; j < h.size(); j++) begin
        idx = m * osr - order - j;
        if (idx >= 0 && idx < bits.size()) acc += bits[idx] ? h[j] : -h[j];
      end
      acc = (acc <<< (64 - ow)) >>> (64 - ow);
      res.push_back(acc);
    end
  endfunction

  // Drive one cycle; a handshake seen with these inputs completes at the next edge.
  task automatic step(input logic v, input logic b, input logic r);
    @(negedge clk);
    bs_valid   = v;
    bs_in      = b;
    dout_ready = r;
    if (dout_valid && r) rec.push_back(longint'(dout));
  endtask

  task automatic step_b(input logic v, input logic b);
    @(negedge clk);
    b_bs_valid = v;
    b_bs_in    = b;
    if (b_dout_valid && b_dout_ready) rec_b.push_back(longint'(b_dout));
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1; bs_valid = 1'b0; dout_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    rec.delete();
  endtask

  task automatic fill_rand(input int n);
    stim.delete();
    repeat (n) stim.push_back(1'($urandom_range(1)));
  endtask

  task automatic run(input int duty, input logic rdy);
    for (int i = 0; i < stim.size(); i++) begin
      while ($urandom_range(99) >= duty) step(1'b0, 1'($urandom_range(1)), rdy);
      step(1'b1, stim[i], rdy);
    end
    repeat (12) step(1'b0, 1'b0, rdy);
  endtask

  task automatic cmp_model(input string name);
    cic_model(stim, 3, 64, A_OW, expq);
    chk({name, "_count"}, rec.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < rec.size()) chk($sformatf("%s_out%0d", name, i), rec[i], expq[i]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   lat;
    tbl[0] = '{"dc_ones",  4'b0001, 1,  262144};
    tbl[1] = '{"dc_zeros", 4'b0000, 1, -262144};
    tbl[2] = '{"alt_10",   4'b0001, 2,       0};
    tbl[3] = '{"pat_1110", 4'b0111, 4,  131072};

    rst_n = 1'b0; clr = 1'b0; bs_valid = 1'b0; bs_in = 1'b0; dout_ready = 1'b0;
    b_rst_n = 1'b0; b_clr = 1'b0; b_bs_valid = 1'b0; b_bs_in = 1'b0; b_dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_ovr", ovr, 0);
    rst_n = 1'b1; b_rst_n = 1'b1;

    // DC and periodic patterns: settled outputs 3 and 4 against fixed gains.
    foreach (tbl[t]) begin
      clr_pulse();
      stim.delete();
      for (int i = 0; i < 256; i++) stim.push_back(tbl[t].pat[i % tbl[t].plen]);
      run(100, 1'b1);
      cmp_model(tbl[t].name);
      for (int m = 2; m < 4; m++)
        if (m < rec.size()) chk($sformatf("%s_settled%0d", tbl[t].name, m), rec[m], tbl[t].settled);
    end

    // Latency: edges from accepting the 64th bit to dout_valid.
    clr_pulse();
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 1'b0);
    lat = -1;
    for (int n = 0; n < 12; n++) begin
      step(1'b0, 1'b0, 1'b0);
      if (dout_valid && lat < 0) lat = n;
    end
    chk("latency_edges", lat, 5);

    // Gapped vs gap-free input must give identical samples.
    clr_pulse();
    fill_rand(320);
    run(30, 1'b1);
    cmp_model("gapped");
    save = rec;
    clr_pulse();
    run(100, 1'b1);
    chk("gapfree_count", rec.size(), save.size());
    for (int i = 0; i < save.size(); i++)
      if (i < rec.size()) chk($sformatf("gap_vs_free%0d", i), rec[i], save[i]);

    // Backpressure across two ticks.
    clr_pulse();
    fill_rand(128);
    cic_model(stim, 3, 64, A_OW, expq);
    for (int i = 0; i < 128; i++) begin
      step(1'b1, stim[i], 1'b0);
      if (i == 100) begin
        chk("bp_first_valid", dout_valid, 1);
        chk("bp_first_dout", longint'(dout), expq[0]);
        chk("bp_first_ovr", ovr, 0);
      end
    end
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("bp_held_dout", longint'(dout), expq[0]);
    chk("bp_held_valid", dout_valid, 1);
    chk("bp_ovr_set", ovr, 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("bp_drained_valid", dout_valid, 0);
    chk("bp_ovr_sticky", ovr, 1);
    chk("bp_one_handshake", rec.size(), 1);
    clr_pulse();
    chk("bp_ovr_cleared", ovr, 0);

    // Handshake coinciding with a new load: no drop, no ovr.
    fill_rand(256);
    cic_model(stim, 3, 64, A_OW, expq);
    for (int s = 0; s < 270; s++) begin
      step(s < 256, s < 256 ? stim[s] : 1'b0, (s >= 132) && (s % 64 == 4));
      if (s >= 133 && s % 64 == 5) begin
        chk($sformatf("sim_dout%0d", s / 64), longint'(dout), expq[s / 64 - 1]);
        chk($sformatf("sim_ovr%0d", s / 64), ovr, 0);
      end
    end
    chk("sim_count", rec.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < rec.size()) chk($sformatf("sim_rec%0d", i), rec[i], expq[i]);

    // Asynchronous reset mid-stream, then a fresh run.
    clr_pulse();
    fill_rand(140);
    for (int i = 0; i < 140; i++) step(1'b1, stim[i], 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("pre_rst_ovr", ovr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", dout_valid, 0);
    chk("arst_ovr", ovr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rec.delete();
    fill_rand(256);
    run(100, 1'b1);
    cmp_model("after_rst");

    // Synchronous clear mid-stream, then a fresh run.
    fill_rand(140);
    for (int i = 0; i < 140; i++) step(1'b1, stim[i], 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("pre_clr_valid", dout_valid, 1);
    @(negedge clk);
    clr = 1'b1; bs_valid = 1'b1; bs_in = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_dout", dout, 0);
    chk("clr_valid", dout_valid, 0);
    chk("clr_ovr", ovr, 0);
    @(negedge clk);
    clr = 1'b0; bs_valid = 1'b0;
    rec.delete();
    fill_rand(256);
    run(100, 1'b1);
    cmp_model("after_clr");

    // ORDER=5, OSR=1024: DC then random, integrators wrap.
    for (int i = 0; i < 5 * 1024; i++) stim_b.push_back(1'b1);
    repeat (3 * 1024) stim_b.push_back(1'($urandom_range(1)));
    for (int i = 0; i < stim_b.size(); i++) begin
      while ($urandom_range(99) >= 80) step_b(1'b0, 1'b0);
      step_b(1'b1, stim_b[i]);
    end
    repeat (12) step_b(1'b0, 1'b0);
    cic_model(stim_b, 5, 1024, B_OW, expq);
    chk("wrap_count", rec_b.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < rec_b.size()) chk($sformatf("wrap_out%0d", i), rec_b[i], expq[i]);
    if (rec_b.size() > 4) chk("wrap_dc_gain", rec_b[4], longint'(1) <<< 50);
    chk("wrap_ovr", b_ovr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
